verificador_paridade: RTL and testbench

VERIFICADOR_PARIDADE -- requirements
Module: verificador_paridade

---
 rtl/verificador_paridade.sv | 143 ++++++++++++++
 tb/tb_verificador_paridade.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/verificador_paridade.sv
// -----------------------------------------------------------------------------
// verificador_paridade
// Checks the parity of 9-bit words (8 data + 1 parity bit), passes the data
// downstream through a one-deep valid/ready register, and tracks link health.
// Health tracking uses a saturating error counter and a three-state FSM:
//   OK -> SUSPEITO after an errored word.
//   SUSPEITO -> FALHA after LIMIAR consecutive errored words (sticky).
//   SUSPEITO -> OK after a good word.
//
// Parameters
//   PARIDADE_IMPAR : 0 = even parity, 1 = odd parity (XOR of all 9 bits)
//   LIMIAR         : consecutive errored words that latch FALHA (1..15)
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous reset, active high
//   entrada        : received word, [7:0] data, [8] parity
//   entrada_valida : upstream word valid
//   entrada_pronta : block can take a word this cycle
//   limpar         : clears error counter, consecutive count and FSM
//   dados          : registered data bits
//   dados_validos  : output word valid
//   dados_pronto   : downstream accepts the output word
//   erro_paridade  : parity error flag travelling with dados
//   contador_erros : saturating count of accepted errored words
//   estado         : FSM state, OK=00 SUSPEITO=01 FALHA=10
//   falha          : high while estado == FALHA
// -----------------------------------------------------------------------------
module verificador_paridade #(
    parameter int PARIDADE_IMPAR = 0,
    parameter int LIMIAR         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] entrada,
    input  logic       entrada_valida,
    output logic       entrada_pronta,
    input  logic       limpar,
    output logic [7:0] dados,
    output logic       dados_validos,
    input  logic       dados_pronto,
    output logic       erro_paridade,
    output logic [7:0] contador_erros,
    output logic [1:0] estado,
    output logic       falha
);

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_SUSPEITO = 2'b01,
        ST_FALHA    = 2'b10
    } estado_t;

    localparam logic       PAR_BIT = 1'(PARIDADE_IMPAR);
    localparam logic [3:0] LIM     = 4'(LIMIAR);

    logic [7:0] dados_q;
    logic       vld_q;
    logic       erro_q;
    logic [7:0] cnt_q,    cnt_d;
    logic [3:0] consec_q, consec_d;
    estado_t    estado_q, estado_d;

    logic       aceita;
    logic       conta;
    logic       erro_entrada;
    logic [3:0] consec_inc;

    // Reset forces ready high: nothing is held while reset is active, and
    // anything offered is dropped because acceptance is masked by rst.
    assign entrada_pronta = rst || !vld_q || dados_pronto;
    assign aceita         = entrada_valida && entrada_pronta && !rst;
    // A word taken together with limpar still flows out but is invisible
    // to the health tracking.
    assign conta          = aceita && !limpar;
    assign erro_entrada   = (^entrada) != PAR_BIT;
    assign consec_inc     = (consec_q == 4'hF) ? 4'hF : consec_q + 4'd1;

    // Output register: load on accept, drop valid on drain without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            dados_q <= 8'd0;
            vld_q   <= 1'b0;
            erro_q  <= 1'b0;
        end else if (aceita) begin
            dados_q <= entrada[7:0];
            erro_q  <= erro_entrada;
            vld_q   <= 1'b1;
        end else if (dados_pronto) begin
            vld_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= ST_OK;
            cnt_q    <= 8'd0;
            consec_q <= 4'd0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            consec_q <= consec_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        consec_d = consec_q;
        if (limpar) begin
            estado_d = ST_OK;
            cnt_d    = 8'd0;
            consec_d = 4'd0;
        end else if (conta) begin
            if (erro_entrada) begin
                cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                consec_d = consec_inc;
            end else begin
                consec_d = 4'd0;
            end
            unique case (estado_q)
                ST_OK, ST_SUSPEITO: begin
                    // From OK the incremented count is 1, so LIMIAR==1
                    // jumps straight to FALHA through the same compare.
                    if (erro_entrada)
                        estado_d = (consec_inc >= LIM) ? ST_FALHA : ST_SUSPEITO;
                    else
                        estado_d = ST_OK;
                end
                ST_FALHA: estado_d = ST_FALHA;
                default:  estado_d = ST_OK;
            endcase
        end
    end

    assign dados          = dados_q;
    assign dados_validos  = vld_q;
    assign erro_paridade  = erro_q;
    assign contador_erros = cnt_q;
    assign estado         = estado_q;
    assign falha          = (estado_q == ST_FALHA);

endmodule

// File: tb/tb_verificador_paridade.sv
module tb_verificador_paridade;

    localparam int PAR = 0;
    localparam int LIM = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] entrada;
    logic       entrada_valida;
    logic       entrada_pronta;
    logic       limpar;
    logic [7:0] dados;
    logic       dados_validos;
    logic       dados_pronto;
    logic       erro_paridade;
    logic [7:0] contador_erros;
    logic [1:0] estado;
    logic       falha;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    verificador_paridade #(.PARIDADE_IMPAR(PAR), .LIMIAR(LIM)) dut (
        .clk            (clk),
        .rst            (rst),
        .entrada        (entrada),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .limpar         (limpar),
        .dados          (dados),
        .dados_validos  (dados_validos),
        .dados_pronto   (dados_pronto),
        .erro_paridade  (erro_paridade),
        .contador_erros (contador_erros),
        .estado         (estado),
        .falha          (falha)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Health is described by the length of the current run of errored words
    // plus a latched failure flag; the state code is derived from those.
    logic [7:0] m_dados;
    logic       m_vld;
    logic       m_err;
    int         m_cnt;
    int         m_run;
    bit         m_fail;
    logic       m_acc;
    logic       m_bad;

    assign m_acc = entrada_valida && !rst && (!m_vld || dados_pronto);
    assign m_bad = ($countones(entrada) % 2) != PAR;

    always @(posedge clk) begin
        if (rst) begin
            m_dados <= 8'd0;
            m_vld   <= 1'b0;
            m_err   <= 1'b0;
            m_cnt   <= 0;
            m_run   <= 0;
            m_fail  <= 1'b0;
        end else begin
            if (m_acc) begin
                m_dados <= entrada[7:0];
                m_err   <= m_bad;
                m_vld   <= 1'b1;
            end else if (dados_pronto) begin
                m_vld   <= 1'b0;
            end
            if (limpar) begin
                m_cnt  <= 0;
                m_run  <= 0;
                m_fail <= 1'b0;
            end else if (m_acc) begin
                if (m_bad) begin
                    m_cnt <= (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                    m_run <= m_run + 1;
                    if (m_run + 1 >= LIM) m_fail <= 1'b1;
                end else begin
                    m_run <= 0;
                end
            end
        end
    end

    function automatic int exp_estado();
        if (m_fail)      return 2;
        else if (m_run > 0) return 1;
        else             return 0;
    endfunction

    task automatic chk(input string nome, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("m_validos", int'(dados_validos),  int'(m_vld));
            chk("m_pronta",  int'(entrada_pronta), int'(rst || !m_vld || dados_pronto));
            chk("m_dados",   int'(dados),          int'(m_dados));
            chk("m_erro",    int'(erro_paridade),  int'(m_err));
            chk("m_cnt",     int'(contador_erros), m_cnt);
            chk("m_estado",  int'(estado),         exp_estado());
            chk("m_falha",   int'(falha),          int'(exp_estado() == 2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; limpar = 1'b0; entrada = 9'd0; entrada_valida = 1'b0; dados_pronto = 1'b1;
        step();
        started = 1'b1;
        step();
        at_neg();
        chk("rst_validos", int'(dados_validos), 0);
        chk("rst_cnt",     int'(contador_erros), 0);
        chk("rst_estado",  int'(estado), 0);
        chk("rst_pronta",  int'(entrada_pronta), 1);
        step();
        rst = 1'b0;

        // pass-through of a good word
        entrada = 9'h0A5; entrada_valida = 1'b1; step(); entrada_valida = 1'b0;
        at_neg();
        chk("pt_dados",  int'(dados), 8'hA5);
        chk("pt_erro",   int'(erro_paridade), 0);
        chk("pt_cnt",    int'(contador_erros), 0);
        chk("pt_estado", int'(estado), 0);

        // single error then recovery
        step();
        entrada = 9'h1A5; entrada_valida = 1'b1; step(); entrada_valida = 1'b0;
        at_neg();
        chk("se_erro",   int'(erro_paridade), 1);
        chk("se_cnt",    int'(contador_erros), 1);
        chk("se_estado", int'(estado), 1);
        step();
        entrada = 9'h0A5; entrada_valida = 1'b1; step(); entrada_valida = 1'b0;
        at_neg();
        chk("rec_estado", int'(estado), 0);
        chk("rec_cnt",    int'(contador_erros), 1);

        // failure latch, stickiness, limpar
        step();
        entrada = 9'h1A5; entrada_valida = 1'b1;
        step(); step();
        at_neg();
        chk("fl_estado2", int'(estado), 1);
        step();
        entrada_valida = 1'b0;
        at_neg();
        chk("fl_estado", int'(estado), 2);
        chk("fl_falha",  int'(falha), 1);
        chk("fl_cnt",    int'(contador_erros), 4);
        step();
        entrada = 9'h0A5; entrada_valida = 1'b1; step(); entrada_valida = 1'b0;
        at_neg();
        chk("fl_sticky", int'(estado), 2);
        step();
        limpar = 1'b1; step(); limpar = 1'b0;
        at_neg();
        chk("lp_estado", int'(estado), 0);
        chk("lp_cnt",    int'(contador_erros), 0);

        // backpressure
        step();
        entrada = 9'h033; entrada_valida = 1'b1; step();
        dados_pronto = 1'b0; entrada = 9'h0C3;
        for (int i = 0; i < 5; i++) begin
            step();
            at_neg();
            chk("bp_pronta", int'(entrada_pronta), 0);
            chk("bp_dados",  int'(dados), 8'h33);
        end
        dados_pronto = 1'b1;
        step(); entrada_valida = 1'b0;
        at_neg();
        chk("bp_new",     int'(dados), 8'hC3);
        chk("bp_new_vld", int'(dados_validos), 1);
        step();
        at_neg();
        chk("bp_drained", int'(dados_validos), 0);

        // saturation
        entrada = 9'h1A5; entrada_valida = 1'b1;
        repeat (300) step();
        entrada_valida = 1'b0;
        at_neg();
        chk("sat_cnt",    int'(contador_erros), 255);
        chk("sat_estado", int'(estado), 2);

        // reset priority over limpar and a held word
        step();
        dados_pronto = 1'b0; entrada = 9'h0F0; entrada_valida = 1'b1; step();
        at_neg();
        chk("hold_vld", int'(dados_validos), 1);
        rst = 1'b1; limpar = 1'b1; step();
        at_neg();
        chk("rp_dados",  int'(dados), 0);
        chk("rp_vld",    int'(dados_validos), 0);
        chk("rp_erro",   int'(erro_paridade), 0);
        chk("rp_cnt",    int'(contador_erros), 0);
        chk("rp_estado", int'(estado), 0);
        chk("rp_falha",  int'(falha), 0);
        chk("rp_pronta", int'(entrada_pronta), 1);
        step();
        at_neg();
        chk("rp_discard", int'(dados_validos), 0);
        rst = 1'b0; limpar = 1'b0; entrada_valida = 1'b0; dados_pronto = 1'b1;
        step();

        // randomized traffic, checked every cycle by the model compare
        for (int i = 0; i < 3000; i++) begin
            entrada        = 9'($urandom_range(0, 511));
            entrada_valida = ($urandom_range(0, 9) < 7);
            dados_pronto   = ($urandom_range(0, 9) < 6);
            limpar         = ($urandom_range(0, 39) == 0);
            rst            = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; limpar = 1'b0; entrada_valida = 1'b0;
        step();
        at_neg();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
